// File: rtl/reg_bus_arbiter_if.sv
// rtl/reg_bus_arbiter_if.sv - master command/response and register-bus signal bundle for reg_bus_arbiter
interface reg_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [15:0] m0_addr;
    logic [1:0]  m0_be;
    logic [15:0] m0_wrdata;
    logic        m0_ack;
    logic        m0_rdvalid;
    logic [15:0] m0_rddata;

    logic        m1_req;
    logic        m1_we;
    logic [15:0] m1_addr;
    logic [1:0]  m1_be;
    logic [15:0] m1_wrdata;
    logic        m1_ack;
    logic        m1_rdvalid;
    logic [15:0] m1_rddata;

    logic [15:0] rdaddr;
    logic [15:0] wraddr;
    logic [1:0]  be;
    logic        write;
    logic [15:0] wrdata;
    logic [15:0] rddata;
    logic        busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_be, m0_wrdata,
        output m0_ack, m0_rdvalid, m0_rddata,
        input  m1_req, m1_we, m1_addr, m1_be, m1_wrdata,
        output m1_ack, m1_rdvalid, m1_rddata,
        output rdaddr, wraddr, be, write, wrdata, busy,
        input  rddata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_be, m0_wrdata,
        input  m0_ack, m0_rdvalid, m0_rddata,
        output m1_req, m1_we, m1_addr, m1_be, m1_wrdata,
        input  m1_ack, m1_rdvalid, m1_rddata,
        input  rdaddr, wraddr, be, write, wrdata, busy,
        output rddata
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - two-master round-robin arbiter for the register bus, one transaction at a time
module reg_bus_arbiter #(
    parameter int          READ_LAT  = 2,
    parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
    input  logic             clk,
    input  logic             sclr,
    reg_bus_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam int         CW     = $clog2(READ_LAT + 2);

    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          last_q,   last_d;
    logic          owner_q,  owner_d;
    logic          write_q,  write_d;
    logic [15:0]   wraddr_q, wraddr_d;
    logic [1:0]    be_q,     be_d;
    logic [15:0]   wrdata_q, wrdata_d;
    logic [15:0]   rdaddr_q, rdaddr_d;
    logic          ack0_q,   ack0_d;
    logic          ack1_q,   ack1_d;
    logic          rv0_q,    rv0_d;
    logic          rv1_q,    rv1_d;
    logic [15:0]   rd0_q,    rd0_d;
    logic [15:0]   rd1_q,    rd1_d;
    logic          busy_q,   busy_d;

    logic          gnt;
    logic          g_we;
    logic [15:0]   g_addr;
    logic [1:0]    g_be;
    logic [15:0]   g_wrdata;

    always_comb begin
        // On contention the master that did not win last time gets the bus.
        gnt      = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
        g_we     = gnt ? bus.m1_we     : bus.m0_we;
        g_addr   = gnt ? bus.m1_addr   : bus.m0_addr;
        g_be     = gnt ? bus.m1_be     : bus.m0_be;
        g_wrdata = gnt ? bus.m1_wrdata : bus.m0_wrdata;

        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        owner_d  = owner_q;
        write_d  = 1'b0;
        wraddr_d = wraddr_q;
        be_d     = be_q;
        wrdata_d = wrdata_q;
        rdaddr_d = rdaddr_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rv0_d    = 1'b0;
        rv1_d    = 1'b0;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;

        case (state_q)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    last_d  = gnt;
                    owner_d = gnt;
                    ack0_d  = ~gnt;
                    ack1_d  = gnt;
                    if (g_we) begin
                        write_d  = 1'b1;
                        wraddr_d = g_addr;
                        be_d     = g_be;
                        wrdata_d = g_wrdata;
                        state_d  = S_WR;
                    end else begin
                        rdaddr_d = g_addr;
                        cnt_d    = CW'(1);
                        state_d  = S_RD;
                    end
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_RD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(READ_LAT)) begin
                    rdaddr_d = IDLE_ADDR;
                end
                // rddata now reflects the address driven READ_LAT cycles ago.
                if (cnt_q == CW'(READ_LAT + 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (owner_q) begin
                        rv1_d = 1'b1;
                        rd1_d = bus.rddata;
                    end else begin
                        rv0_d = 1'b1;
                        rd0_d = bus.rddata;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                rdaddr_d = IDLE_ADDR;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            write_q  <= 1'b0;
            wraddr_q <= '0;
            be_q     <= '0;
            wrdata_q <= '0;
            rdaddr_q <= IDLE_ADDR;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rd0_q    <= '0;
            rd1_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            write_q  <= write_d;
            wraddr_q <= wraddr_d;
            be_q     <= be_d;
            wrdata_q <= wrdata_d;
            rdaddr_q <= rdaddr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd1_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.write      = write_q;
    assign bus.wraddr     = wraddr_q;
    assign bus.be         = be_q;
    assign bus.wrdata     = wrdata_q;
    assign bus.rdaddr     = rdaddr_q;
    assign bus.m0_ack     = ack0_q;
    assign bus.m1_ack     = ack1_q;
    assign bus.m0_rdvalid = rv0_q;
    assign bus.m1_rdvalid = rv1_q;
    assign bus.m0_rddata  = rd0_q;
    assign bus.m1_rddata  = rd1_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - self-checking bench for reg_bus_arbiter with a transaction-schedule model
module tb_reg_bus_arbiter;
    localparam int RL = 2;
    localparam int N  = 2048;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] data;
    } cmd_t;

    logic clk  = 1'b0;
    logic sclr = 1'b1;
    always #5 clk = ~clk;

    reg_bus_arbiter_if bus();

    reg_bus_arbiter #(.READ_LAT(RL), .IDLE_ADDR(16'hFFFF)) dut (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus)
    );

    cmd_t q0[$];
    cmd_t q1[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Expected per-cycle events, filled in ahead of time when the model grants.
    bit          ev_rst[N], ev_wr[N], ev_ack0[N], ev_ack1[N], ev_busy[N];
    bit          ev_rda_v[N], ev_rv0[N], ev_rv1[N];
    logic [15:0] ev_wraddr[N], ev_wrdata[N], ev_rda[N], ev_rdd0[N], ev_rdd1[N];
    logic [1:0]  ev_be[N];
    logic [15:0] addr_hist[N];

    int          free_at = 0;
    bit          last_g  = 1'b1;
    bit          armed   = 1'b0;
    logic [15:0] h_wraddr, h_wrdata, h_rd0, h_rd1;
    logic [1:0]  h_be;

    int          n_write, n_adj, n_rv0, n_rv1, n_rda, n_rda_0100, n_busy;
    int          ack_log[$];
    int          ack_cyc[$];
    logic [15:0] o_wraddr, o_wrdata, o_rd1;
    bit          prev_write;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        if (a == 16'hFFFF) return 16'h0000;
        if (a == 16'h0100) return 16'h1234;
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int c);
        bit   r0, r1, g;
        cmd_t cm;
        if (c >= N - RL - 4) return;
        if (sclr) begin
            for (int k = c + 1; k < c + RL + 4; k++) begin
                ev_rst[k] = 0; ev_wr[k] = 0; ev_ack0[k] = 0; ev_ack1[k] = 0; ev_busy[k] = 0;
                ev_rda_v[k] = 0; ev_rv0[k] = 0; ev_rv1[k] = 0;
            end
            ev_rst[c+1] = 1;
            free_at     = c + 1;
            last_g      = 1'b1;
            return;
        end
        r0 = (bus.m0_req === 1'b1);
        r1 = (bus.m1_req === 1'b1);
        if (c < free_at || !(r0 || r1)) return;
        g      = (r0 && r1) ? !last_g : r1;
        last_g = g;
        cm = g ? cmd_t'{bus.m1_we, bus.m1_addr, bus.m1_be, bus.m1_wrdata}
               : cmd_t'{bus.m0_we, bus.m0_addr, bus.m0_be, bus.m0_wrdata};
        if (g) ev_ack1[c+1] = 1; else ev_ack0[c+1] = 1;
        ev_busy[c+1] = 1;
        if (cm.we) begin
            ev_wr[c+1]     = 1;
            ev_wraddr[c+1] = cm.addr;
            ev_be[c+1]     = cm.be;
            ev_wrdata[c+1] = cm.data;
            free_at        = c + 2;
        end else begin
            for (int k = 1; k <= RL; k++) begin
                ev_rda_v[c+k] = 1;
                ev_rda[c+k]   = cm.addr;
            end
            for (int k = 2; k <= RL + 1; k++) ev_busy[c+k] = 1;
            if (g) begin ev_rv1[c+2+RL] = 1; ev_rdd1[c+2+RL] = mem_f(cm.addr); end
            else   begin ev_rv0[c+2+RL] = 1; ev_rdd0[c+2+RL] = mem_f(cm.addr); end
            free_at = c + 2 + RL;
        end
    endtask

    // Compare and model process: one pass per cycle, away from the active edge.
    initial forever begin
        int c;
        @(negedge clk);
        c = cyc;
        addr_hist[c] = bus.rdaddr;
        if (ev_rst[c]) begin
            armed = 1; h_wraddr = 0; h_wrdata = 0; h_be = 0; h_rd0 = 0; h_rd1 = 0;
        end
        if (ev_wr[c]) begin h_wraddr = ev_wraddr[c]; h_be = ev_be[c]; h_wrdata = ev_wrdata[c]; end
        if (ev_rv0[c]) h_rd0 = ev_rdd0[c];
        if (ev_rv1[c]) h_rd1 = ev_rdd1[c];
        if (armed) begin
            chk("write",      bus.write,      ev_wr[c]);
            chk("wraddr",     bus.wraddr,     h_wraddr);
            chk("be",         bus.be,         h_be);
            chk("wrdata",     bus.wrdata,     h_wrdata);
            chk("m0_ack",     bus.m0_ack,     ev_ack0[c]);
            chk("m1_ack",     bus.m1_ack,     ev_ack1[c]);
            chk("m0_rdvalid", bus.m0_rdvalid, ev_rv0[c]);
            chk("m1_rdvalid", bus.m1_rdvalid, ev_rv1[c]);
            chk("m0_rddata",  bus.m0_rddata,  h_rd0);
            chk("m1_rddata",  bus.m1_rddata,  h_rd1);
            chk("rdaddr",     bus.rdaddr,     ev_rda_v[c] ? ev_rda[c] : 16'hFFFF);
            chk("busy",       bus.busy,       ev_busy[c]);
            if (bus.write === 1'b1) begin
                n_write++;
                if (prev_write) n_adj++;
                o_wraddr = bus.wraddr;
                o_wrdata = bus.wrdata;
            end
            prev_write = (bus.write === 1'b1);
            if (bus.m0_ack === 1'b1) begin ack_log.push_back(0); ack_cyc.push_back(c); end
            if (bus.m1_ack === 1'b1) begin ack_log.push_back(1); ack_cyc.push_back(c); end
            if (bus.m0_rdvalid === 1'b1) n_rv0++;
            if (bus.m1_rdvalid === 1'b1) begin n_rv1++; o_rd1 = bus.m1_rddata; end
            if (bus.rdaddr !== 16'hFFFF) n_rda++;
            if (bus.rdaddr === 16'h0100) n_rda_0100++;
            if (bus.busy === 1'b1) n_busy++;
        end
        model_step(c);
    end

    // Register bus stand-in: rddata returns the value for the address seen RL cycles earlier.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (cyc >= N - 8) begin
            $display("FAIL cycle budget exhausted at cycle %0d", cyc);
            $fatal(1, "cycle budget");
        end
        #1;
        bus.rddata = (cyc > RL + 1) ? mem_f(addr_hist[cyc-RL]) : 16'h0000;
    end

    initial begin
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_be = 0; bus.m0_wrdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_be = 0; bus.m1_wrdata = 0;
        bus.rddata = 0;
    end

    initial forever begin
        logic a;
        @(negedge clk);
        a = bus.m0_ack;
        @(posedge clk);
        #1;
        if (a === 1'b1 && q0.size() > 0) void'(q0.pop_front());
        if (q0.size() > 0) begin
            bus.m0_req = 1'b1;
            {bus.m0_we, bus.m0_addr, bus.m0_be, bus.m0_wrdata} = q0[0];
        end else bus.m0_req = 1'b0;
    end

    initial forever begin
        logic a;
        @(negedge clk);
        a = bus.m1_ack;
        @(posedge clk);
        #1;
        if (a === 1'b1 && q1.size() > 0) void'(q1.pop_front());
        if (q1.size() > 0) begin
            bus.m1_req = 1'b1;
            {bus.m1_we, bus.m1_addr, bus.m1_be, bus.m1_wrdata} = q1[0];
        end else bus.m1_req = 1'b0;
    end

    task automatic push(input int m, input logic we, input logic [15:0] addr,
                        input logic [1:0] be, input logic [15:0] data);
        if (m == 0) q0.push_back(cmd_t'{we, addr, be, data});
        else        q1.push_back(cmd_t'{we, addr, be, data});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        n_write = 0; n_adj = 0; n_rv0 = 0; n_rv1 = 0; n_rda = 0; n_rda_0100 = 0; n_busy = 0;
        ack_log.delete(); ack_cyc.delete();
        o_wraddr = 0; o_wrdata = 0; o_rd1 = 0;
    endtask

    task automatic wait_done(input int lim);
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || cyc <= free_at + 1) && t < lim) begin
            step(1);
            t++;
        end
        vectors++;
        if (t >= lim) begin
            miscompares++;
            $display("FAIL wait_done timeout at cycle %0d: got %0d cycles, expected < %0d", cyc, t, lim);
        end
    endtask

    initial begin
        int t;
        clear_obs();
        step(3);
        sclr = 1'b0;
        @(negedge clk);
        chk("rst_busy",   bus.busy,   16'h0000);
        chk("rst_rdaddr", bus.rdaddr, 16'hFFFF);
        chk("rst_write",  bus.write,  16'h0000);
        step(1);

        // Single m0 write
        clear_obs();
        push(0, 1'b1, 16'h0184, 2'b11, 16'hA5A5);
        wait_done(100);
        chk("t1_nwrite",  16'(n_write), 16'd1);
        chk("t1_nack",    16'(ack_log.size()), 16'd1);
        if (ack_log.size() == 1) chk("t1_ack_m0", 16'(ack_log[0]), 16'd0);
        chk("t1_wraddr",  o_wraddr, 16'h0184);
        chk("t1_wrdata",  o_wrdata, 16'hA5A5);

        // Single m1 read
        clear_obs();
        push(1, 1'b0, 16'h0100, 2'b00, 16'h0000);
        wait_done(100);
        chk("t2_nrv1",    16'(n_rv1), 16'd1);
        chk("t2_rddata",  o_rd1, 16'h1234);
        chk("t2_rda0100", 16'(n_rda_0100), 16'd2);
        chk("t2_rda_any", 16'(n_rda), 16'd2);

        // Both request in the first cycle after reset
        step(1);
        sclr = 1'b1;
        push(0, 1'b1, 16'h0010, 2'b11, 16'h1111);
        push(1, 1'b1, 16'h0020, 2'b11, 16'h2222);
        step(2);
        clear_obs();
        sclr = 1'b0;
        wait_done(100);
        chk("t3_nack", 16'(ack_log.size()), 16'd2);
        if (ack_log.size() == 2) begin
            chk("t3_first_m0",  16'(ack_log[0]), 16'd0);
            chk("t3_second_m1", 16'(ack_log[1]), 16'd1);
            chk("t3_ack_gap",   16'(ack_cyc[1] - ack_cyc[0]), 16'd2);
        end

        // Continuous writes from both masters
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            push(0, 1'b1, 16'h0200 + 16'(i), 2'b01, 16'hC000 + 16'(i));
            push(1, 1'b1, 16'h0300 + 16'(i), 2'b10, 16'hD000 + 16'(i));
        end
        wait_done(200);
        chk("t4_nwrite", 16'(n_write), 16'd40);
        chk("t4_adj",    16'(n_adj),   16'd0);
        chk("t4_nack",   16'(ack_log.size()), 16'd40);
        for (int i = 1; i < ack_log.size(); i++)
            chk("t4_alternate", 16'(ack_log[i]), 16'(1 - ack_log[i-1]));

        // Reset in the cycle after a read is issued
        clear_obs();
        push(0, 1'b0, 16'h0200, 2'b00, 16'h0000);
        t = 0;
        while (bus.m0_ack !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("t5_ack_seen", 16'(bus.m0_ack === 1'b1), 16'd1);
        step(1);
        sclr = 1'b1;
        step(1);
        sclr = 1'b0;
        @(negedge clk);
        chk("t5_rdaddr", bus.rdaddr, 16'hFFFF);
        chk("t5_busy",   bus.busy,   16'h0000);
        step(8);
        chk("t5_nrv0",   16'(n_rv0), 16'd0);

        // Idle for 100 cycles
        clear_obs();
        step(100);
        chk("t6_nwrite", 16'(n_write), 16'd0);
        chk("t6_nack",   16'(ack_log.size()), 16'd0);
        chk("t6_nrv",    16'(n_rv0 + n_rv1), 16'd0);
        chk("t6_nbusy",  16'(n_busy), 16'd0);
        chk("t6_nrda",   16'(n_rda), 16'd0);

        // Mixed traffic, checked cycle by cycle against the model
        push(0, 1'b1, 16'h0011, 2'b01, 16'hBEEF);
        push(0, 1'b0, 16'h0184, 2'b00, 16'h0000);
        push(0, 1'b1, 16'h0012, 2'b10, 16'h0F0F);
        push(1, 1'b0, 16'h0030, 2'b11, 16'h0000);
        push(1, 1'b0, 16'h0100, 2'b00, 16'h0000);
        push(1, 1'b1, 16'h0040, 2'b11, 16'h7777);
        wait_done(200);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
